// File: rtl/aes_inv_cipher_if.sv
// Byte-stream bus of the AES-128 decryption core: ciphertext/key beats in, plaintext bytes out.
interface aes_inv_cipher_if;
  logic [7:0] ct_in;
  logic [7:0] key_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] pt_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output ct_in, key_in, in_valid, out_ready,
    input  in_ready, pt_out, out_valid, busy
  );

  modport slave (
    input  ct_in, key_in, in_valid, out_ready,
    output in_ready, pt_out, out_valid, busy
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// Byte-serial AES-128 inverse cipher, one round per clock, with backwards key expansion
// from the round-10 key. GF(2^8) helpers and the two S-box leaves live alongside the top.
package aes_inv_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 by square-and-multiply (exponent 0b11111110); maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_inv_pkg::*;
  logic [7:0] w_inv;
  assign w_inv = gf_inv(i_a);
  assign o_s   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_inv_pkg::*;
  logic [7:0] w_aff;
  assign w_aff = {i_a[6:0], i_a[7]} ^ {i_a[4:0], i_a[7:5]} ^ {i_a[1:0], i_a[7:2]} ^ 8'h05;
  assign o_s   = gf_inv(w_aff);
endmodule

// state | meaning
// LOAD  | accept 16 ct/key beats
// ADDK  | xor in round-10 key
// ROUND | rounds 9..1, key walked backwards each cycle
// FINAL | round 0, no InvMixColumns
// OUT   | stream 16 plaintext bytes
module aes_inv_cipher #(
  parameter bit ZERO_IDLE_OUT = 1'b1
) (
  input logic             clk,
  input logic             rst,
  aes_inv_cipher_if.slave bus
);
  import aes_inv_pkg::*;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_ADDK  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0] r_fsm;
  logic [3:0] r_byte_cnt;
  logic [3:0] r_round;
  logic [7:0] r_state [16];
  logic [7:0] r_key   [16];
  logic [7:0] r_pt_hold;

  logic [7:0] w_isr     [16];
  logic [7:0] w_isb     [16];
  logic [7:0] w_ark     [16];
  logic [7:0] w_imc     [16];
  logic [7:0] w_key_nxt [16];
  logic [7:0] w_w3n     [4];
  logic [7:0] w_sub     [4];
  logic [7:0] w_rcon;
  logic       w_in_fire;
  logic       w_out_valid;
  logic       w_out_fire;

  assign w_in_fire   = (r_fsm == S_LOAD) && bus.in_valid;
  assign w_out_valid = (r_fsm == S_OUT);
  assign w_out_fire  = w_out_valid && bus.out_ready;

  // state byte index = 4*col + row; row r rotates right by r
  for (genvar g = 0; g < 16; g++) begin : g_byte
    localparam int ROW = g % 4;
    localparam int COL = g / 4;
    assign w_isr[g] = r_state[((COL - ROW + 4) % 4) * 4 + ROW];
    aes_inv_sbox u_isb (.i_a(w_isr[g]), .o_s(w_isb[g]));
    assign w_ark[g] = w_isb[g] ^ w_key_nxt[g];
  end

  for (genvar g = 0; g < 4; g++) begin : g_key
    assign w_w3n[g] = r_key[12 + g] ^ r_key[8 + g];
    aes_sbox u_sbox (.i_a(w_w3n[(g + 1) % 4]), .o_s(w_sub[g]));
  end

  // r_round is 0 in FINAL, which yields Rcon(1)
  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd9:    w_rcon = 8'h36;
      4'd8:    w_rcon = 8'h1b;
      4'd7:    w_rcon = 8'h80;
      4'd6:    w_rcon = 8'h40;
      4'd5:    w_rcon = 8'h20;
      4'd4:    w_rcon = 8'h10;
      4'd3:    w_rcon = 8'h08;
      4'd2:    w_rcon = 8'h04;
      4'd1:    w_rcon = 8'h02;
      4'd0:    w_rcon = 8'h01;
      default: w_rcon = 8'h00;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_key_nxt[12 + i] = w_w3n[i];
      w_key_nxt[8 + i]  = r_key[8 + i] ^ r_key[4 + i];
      w_key_nxt[4 + i]  = r_key[4 + i] ^ r_key[i];
      w_key_nxt[i]      = r_key[i] ^ w_sub[i] ^ ((i == 0) ? w_rcon : 8'h00);
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_imc[4*c + 0] = gf_mul(w_ark[4*c], 8'h0e) ^ gf_mul(w_ark[4*c + 1], 8'h0b)
                     ^ gf_mul(w_ark[4*c + 2], 8'h0d) ^ gf_mul(w_ark[4*c + 3], 8'h09);
      w_imc[4*c + 1] = gf_mul(w_ark[4*c], 8'h09) ^ gf_mul(w_ark[4*c + 1], 8'h0e)
                     ^ gf_mul(w_ark[4*c + 2], 8'h0b) ^ gf_mul(w_ark[4*c + 3], 8'h0d);
      w_imc[4*c + 2] = gf_mul(w_ark[4*c], 8'h0d) ^ gf_mul(w_ark[4*c + 1], 8'h09)
                     ^ gf_mul(w_ark[4*c + 2], 8'h0e) ^ gf_mul(w_ark[4*c + 3], 8'h0b);
      w_imc[4*c + 3] = gf_mul(w_ark[4*c], 8'h0b) ^ gf_mul(w_ark[4*c + 1], 8'h0d)
                     ^ gf_mul(w_ark[4*c + 2], 8'h09) ^ gf_mul(w_ark[4*c + 3], 8'h0e);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= S_LOAD;
      r_byte_cnt <= 4'd0;
      r_round    <= 4'd9;
      r_pt_hold  <= 8'h00;
    end else begin
      case (r_fsm)
        S_LOAD: if (w_in_fire) begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) r_fsm <= S_ADDK;
        end
        S_ADDK: begin
          r_round <= 4'd9;
          r_fsm   <= S_ROUND;
        end
        S_ROUND: begin
          r_round <= r_round - 4'd1;
          if (r_round == 4'd1) r_fsm <= S_FINAL;
        end
        S_FINAL: r_fsm <= S_OUT;
        S_OUT: if (w_out_fire) begin
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) r_fsm <= S_LOAD;
        end
        default: r_fsm <= S_LOAD;
      endcase
      if (w_out_valid) r_pt_hold <= r_state[r_byte_cnt];
    end
  end

  // datapath registers carry no reset; their contents are meaningless until a full load
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (r_fsm)
        S_LOAD: if (w_in_fire) begin
          r_state[r_byte_cnt] <= bus.ct_in;
          r_key[r_byte_cnt]   <= bus.key_in;
        end
        S_ADDK: for (int i = 0; i < 16; i++) r_state[i] <= r_state[i] ^ r_key[i];
        S_ROUND: for (int i = 0; i < 16; i++) begin
          r_state[i] <= w_imc[i];
          r_key[i]   <= w_key_nxt[i];
        end
        S_FINAL: for (int i = 0; i < 16; i++) begin
          r_state[i] <= w_ark[i];
          r_key[i]   <= w_key_nxt[i];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_fsm == S_LOAD);
  assign bus.busy      = (r_fsm != S_LOAD);
  assign bus.out_valid = w_out_valid;
  assign bus.pt_out    = w_out_valid ? r_state[r_byte_cnt] :
                         (ZERO_IDLE_OUT ? 8'h00 : r_pt_hold);
endmodule
